// File: rtl/hm_disp_pkg.sv
// Shared constants and types for the seven-segment display scanner.
package hm_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [2:0] LAST_RT   = 3'd3;
  localparam logic [2:0] LAST_PM   = 3'd2;
  localparam logic [2:0] DP_IDX_RT = 3'd3;

endpackage

// File: rtl/seg7_dec_hm.sv
// BCD to active-low seven-segment pattern {g,f,e,d,c,b,a}; 10-15 show a dash.
module seg7_dec_hm
  import hm_disp_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg_l
);

  always_comb begin
    o_seg_l = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg_l = 7'h40;
      4'd1: o_seg_l = 7'h79;
      4'd2: o_seg_l = 7'h24;
      4'd3: o_seg_l = 7'h30;
      4'd4: o_seg_l = 7'h19;
      4'd5: o_seg_l = 7'h12;
      4'd6: o_seg_l = 7'h02;
      4'd7: o_seg_l = 7'h78;
      4'd8: o_seg_l = 7'h00;
      4'd9: o_seg_l = 7'h10;
      default: o_seg_l = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_hm.sv
// Seven-segment scanner: drives the digit index for the anode decoder plus the
// matching segment/decimal-point data from a shadow copy updated only at frame boundaries.
module disp_scan_hm
  import hm_disp_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       rs_en,
  input  logic       upd_req,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic       upd_ack,
  output logic [2:0] a,
  output logic [6:0] seg_l,
  output logic       dp_l
);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_a;
  logic [6:0]       r_seg_l;
  logic             r_dp_l;
  logic             r_ack;
  logic [15:0]      r_shadow;
  logic [15:0]      r_pend;
  logic             r_pend_v;

  logic        w_tick;
  logic [2:0]  w_last;
  logic        w_wrap;
  logic        w_bound;
  logic [2:0]  w_next_a;
  logic [15:0] w_din;
  logic [15:0] w_shadow_nxt;
  bcd_t        w_digit;
  logic [6:0]  w_pat;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;

  assign w_tick   = (r_cnt == CNT_W'(REFRESH_COUNT - 1));
  assign w_last   = mode ? LAST_PM : LAST_RT;
  assign w_wrap   = (r_a >= w_last);
  assign w_bound  = w_tick && w_wrap;
  assign w_next_a = w_wrap ? 3'd0 : r_a + 3'd1;
  assign w_din    = {d3, d2, d1, d0};

  // Update handshake: upd_req is a one-cycle strobe marking d3..d0 valid; the
  // digits are held as pending (latest wins) and copied into the shadow at the
  // next frame boundary, which is acknowledged by a one-cycle upd_ack after it.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_bound) begin
      if (upd_req)       w_shadow_nxt = w_din;
      else if (r_pend_v) w_shadow_nxt = r_pend;
    end
  end

  // The new frame's first digit must already come from the freshly loaded shadow.
  always_comb begin
    w_digit = w_shadow_nxt[3:0];
    case (w_next_a[1:0])
      2'd0: w_digit = w_shadow_nxt[3:0];
      2'd1: w_digit = w_shadow_nxt[7:4];
      2'd2: w_digit = w_shadow_nxt[11:8];
      2'd3: w_digit = w_shadow_nxt[15:12];
      default: w_digit = w_shadow_nxt[3:0];
    endcase
  end

  seg7_dec_hm u_dec (
    .i_bcd   (w_digit),
    .o_seg_l (w_pat)
  );

  always_comb begin
    w_seg_nxt = w_pat;
    w_dp_nxt  = 1'b1;
    if (!mode) begin
      if (!rs_en) begin
        w_seg_nxt = SEG_BLANK;
      end else begin
        w_dp_nxt = (w_next_a != DP_IDX_RT);
      end
    end else begin
      // Leading-zero blanking on the three-digit pulse display.
      if (w_next_a == 3'd2 && w_shadow_nxt[11:8] == 4'd0)
        w_seg_nxt = SEG_BLANK;
      if (w_next_a == 3'd1 && w_shadow_nxt[11:8] == 4'd0 && w_shadow_nxt[7:4] == 4'd0)
        w_seg_nxt = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_ack    <= 1'b0;
    end else if (w_bound) begin
      r_shadow <= w_shadow_nxt;
      r_pend_v <= 1'b0;
      r_ack    <= upd_req | r_pend_v;
    end else begin
      r_ack <= 1'b0;
      if (upd_req) begin
        r_pend   <= w_din;
        r_pend_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= 3'd0;
      r_seg_l <= SEG_BLANK;
      r_dp_l  <= 1'b1;
    end else if (w_tick) begin
      r_a     <= w_next_a;
      r_seg_l <= w_seg_nxt;
      r_dp_l  <= w_dp_nxt;
    end
  end

  assign a       = r_a;
  assign seg_l   = r_seg_l;
  assign dp_l    = r_dp_l;
  assign upd_ack = r_ack;

endmodule

// File: tb/tb_disp_scan_hm.sv
// Scoreboard bench for disp_scan_hm with a short refresh period: the driver queues
// hand-computed per-tick outputs and ack cycles, a negedge monitor pops and compares.
module tb_disp_scan_hm;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       rs_en;
  logic       upd_req;
  logic [3:0] d0, d1, d2, d3;
  logic       upd_ack;
  logic [2:0] a;
  logic [6:0] seg_l;
  logic       dp_l;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ph     = 0;

  logic [10:0] exp_q[$];
  int          ack_q[$];

  disp_scan_hm #(.REFRESH_COUNT(RC), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .rs_en   (rs_en),
    .upd_req (upd_req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .upd_ack (upd_ack),
    .a       (a),
    .seg_l   (seg_l),
    .dp_l    (dp_l)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  logic [2:0] prev_a   = 3'd0;
  logic       prev_rst = 1'b0;
  int         hold     = -1;

  always @(negedge clk) begin
    logic [10:0] e;
    logic        exp_ack;
    if (rst) begin
      if (!prev_rst) begin
        check("reset_a", int'(a), 0);
        check("reset_seg_l", int'(seg_l), 'h7F);
        check("reset_dp_l", int'(dp_l), 1);
        check("reset_upd_ack", int'(upd_ack), 0);
      end
      hold   = -1;
      prev_a = a;
    end else begin
      if (a != prev_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_tick: a went %0d->%0d with nothing expected", prev_a, a);
        end else begin
          e = exp_q.pop_front();
          check("tick_a", int'(a), int'(e[10:8]));
          check("tick_seg_l", int'(seg_l), int'(e[7:1]));
          check("tick_dp_l", int'(dp_l), int'(e[0]));
          check("hold_cycles", hold, RC - 1);
        end
        hold   = 0;
        prev_a = a;
      end else begin
        hold++;
      end
      exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
      if (upd_ack || exp_ack) begin
        check("upd_ack", int'(upd_ack), int'(exp_ack));
        if (exp_ack) void'(ack_q.pop_front());
      end
    end
    prev_rst = rst;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % RC;
  endtask

  task automatic tk(input logic [2:0] ea, input logic [6:0] es, input logic ed);
    exp_q.push_back({ea, es, ed});
    do step(); while (ph != 0);
  endtask

  task automatic ack_now();
    ack_q.push_back(cyc);
  endtask

  task automatic req(input logic [3:0] v3, input logic [3:0] v2,
                     input logic [3:0] v1, input logic [3:0] v0);
    d3 = v3; d2 = v2; d1 = v1; d0 = v0;
    upd_req = 1'b1;
    step();
    upd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; rs_en = 1'b1; upd_req = 1'b0;
    d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ph  = 0;

    // first frame shows the zero shadow, then 8108 after the boundary
    req(4'd8, 4'd1, 4'd0, 4'd8);
    tk(3'd1, 7'h40, 1'b1);
    tk(3'd2, 7'h40, 1'b1);
    tk(3'd3, 7'h40, 1'b0);
    tk(3'd0, 7'h00, 1'b1); ack_now();
    tk(3'd1, 7'h40, 1'b1);
    tk(3'd2, 7'h79, 1'b1);
    tk(3'd3, 7'h00, 1'b0);

    // switch to pulse mode while a=3, load 007 with leading-zero blanking
    mode = 1'b1;
    req(4'd0, 4'd0, 4'd0, 4'd7);
    tk(3'd0, 7'h78, 1'b1); ack_now();
    tk(3'd1, 7'h7F, 1'b1);
    tk(3'd2, 7'h7F, 1'b1);
    tk(3'd0, 7'h78, 1'b1);
    tk(3'd1, 7'h7F, 1'b1);

    // reaction mode with display disabled, then re-enabled
    mode = 1'b0; rs_en = 1'b0;
    tk(3'd2, 7'h7F, 1'b1);
    tk(3'd3, 7'h7F, 1'b1);
    tk(3'd0, 7'h7F, 1'b1);
    tk(3'd1, 7'h7F, 1'b1);
    rs_en = 1'b1;
    tk(3'd2, 7'h40, 1'b1);
    tk(3'd3, 7'h40, 1'b0);
    tk(3'd0, 7'h78, 1'b1);

    // two requests in one frame: latest wins, single ack
    req(4'd5, 4'd5, 4'd5, 4'd5);
    req(4'd1, 4'd2, 4'd3, 4'd4);
    tk(3'd1, 7'h40, 1'b1);
    tk(3'd2, 7'h40, 1'b1);
    tk(3'd3, 7'h40, 1'b0);
    tk(3'd0, 7'h19, 1'b1); ack_now();
    tk(3'd1, 7'h30, 1'b1);
    tk(3'd2, 7'h24, 1'b1);
    tk(3'd3, 7'h79, 1'b0);

    // request coincident with the boundary bypasses pending
    step(); step(); step();
    exp_q.push_back({3'd0, 7'h3F, 1'b1});
    req(4'd9, 4'd6, 4'd5, 4'hF); ack_now();
    tk(3'd1, 7'h12, 1'b1);
    tk(3'd2, 7'h02, 1'b1);
    tk(3'd3, 7'h10, 1'b0);

    // reset mid-frame with a pending update: no ack, shadow cleared
    req(4'd2, 4'd2, 4'd2, 4'd2);
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    ph  = 0;
    tk(3'd1, 7'h40, 1'b1);
    tk(3'd2, 7'h40, 1'b1);
    tk(3'd3, 7'h40, 1'b0);
    tk(3'd0, 7'h40, 1'b1);
    tk(3'd1, 7'h40, 1'b1);

    repeat (RC) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
